// File: rtl/shift_arbiter.sv
// shift_arbiter: two-requester arbiter in front of a shared external shifter.
// Each accepted operation is latched, sent to the shifter for one cycle, and
// its result is held on the response channel until it is taken.
// PRIO_REQ0 = 0 selects round-robin arbitration; 1 selects fixed priority with req0 first.
// Optional carry-out support is enabled by defining the macro SHIFT_ARB_CARRY_EN.
module shift_arbiter #(
    parameter int PRIO_REQ0 = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [4:0]  req0_shamt,
    input  logic [1:0]  req0_shtype,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [4:0]  req1_shamt,
    input  logic [1:0]  req1_shtype,
`ifdef SHIFT_ARB_CARRY_EN
    input  logic        req0_cin,
    input  logic        req1_cin,
    output logic        rsp_c,
`endif
    output logic [31:0] sh_a,
    output logic [4:0]  sh_shamt,
    output logic [1:0]  sh_shtype,
    input  logic [31:0] sh_y,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_y,
    output logic        rsp_id
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state, state_nxt;
    logic        ptr;
    logic        grant0, grant1, accept;
    logic [31:0] op_a;
    logic [4:0]  op_shamt;
    logic [1:0]  op_shtype;
    logic        op_id;
    logic [31:0] y_q;
    logic        id_q;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: grants only in IDLE (and never under reset), response valid in RESP
    always_comb begin
        grant0    = 1'b0;
        grant1    = 1'b0;
        rsp_valid = (state == RESP);
        if (state == IDLE && reset_n) begin
            if (req0_valid && (!req1_valid || PRIO_REQ0 != 0 || !ptr))
                grant0 = 1'b1;
            else if (req1_valid)
                grant1 = 1'b1;
        end
    end

    assign accept     = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Latch the winner's operands; pointer moves to the requester that lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr       <= 1'b0;
            op_a      <= '0;
            op_shamt  <= '0;
            op_shtype <= '0;
            op_id     <= 1'b0;
        end else if (accept) begin
            ptr       <= grant0;
            op_id     <= grant1;
            op_a      <= grant0 ? req0_a      : req1_a;
            op_shamt  <= grant0 ? req0_shamt  : req1_shamt;
            op_shtype <= grant0 ? req0_shtype : req1_shtype;
        end
    end

    assign sh_a      = op_a;
    assign sh_shamt  = op_shamt;
    assign sh_shtype = op_shtype;

    // Capture the shifter result during EXEC
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            y_q  <= '0;
            id_q <= 1'b0;
        end else if (state == EXEC) begin
            y_q  <= sh_y;
            id_q <= op_id;
        end
    end

    assign rsp_y  = y_q;
    assign rsp_id = id_q;

`ifdef SHIFT_ARB_CARRY_EN
    logic       op_cin;
    logic       c_q;
    logic       c_nxt;
    logic [4:0] lsl_idx;
    logic [4:0] lsr_idx;

    // 32 - shamt wraps to the right 5-bit index for every nonzero shamt
    assign lsl_idx = 5'd0 - op_shamt;
    assign lsr_idx = op_shamt - 5'd1;

    // Carry-out select from the latched operand
    always_comb begin
        c_nxt = op_cin;
        if (op_shamt != 5'd0) begin
            unique case (op_shtype)
                2'b00:   c_nxt = op_a[lsl_idx];
                2'b01,
                2'b10:   c_nxt = op_a[lsr_idx];
                default: c_nxt = sh_y[31];
            endcase
        end
    end

    // Carry-in latch and carry-out register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_cin <= 1'b0;
            c_q    <= 1'b0;
        end else begin
            if (accept)        op_cin <= grant0 ? req0_cin : req1_cin;
            if (state == EXEC) c_q    <= c_nxt;
        end
    end

    assign rsp_c = c_q;
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Testbench for shift_arbiter: a round-robin instance and a fixed-priority
// instance share one stimulus stream, and each has its own scoreboard queue.
// Carry checks are included when SHIFT_ARB_CARRY_EN is defined.
module tb_shift_arbiter;

    typedef struct packed {
        logic [31:0] y;
        logic        id;
        logic        c;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        reset_n;
    logic        v0, v1, rr;
    logic [31:0] a0, a1;
    logic [4:0]  s0, s1;
    logic [1:0]  t0, t1;
    logic        cin0, cin1;

    logic        rdy0 [2];
    logic        rdy1 [2];
    logic [31:0] sha  [2];
    logic [4:0]  shs  [2];
    logic [1:0]  sht  [2];
    logic [31:0] shy  [2];
    logic        rv   [2];
    logic [31:0] ry   [2];
    logic        rid  [2];
    logic        rc   [2];

    int   tests = 0;
    int   fails = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic busy [2];
    logic ptr  [2];

    function automatic logic [31:0] ref_shift(logic [31:0] a, logic [4:0] sh, logic [1:0] t);
        logic [63:0] w;
        case (t)
            2'b00:   return a << sh;
            2'b01:   return a >> sh;
            2'b10:   return 32'($signed(a) >>> sh);
            default: begin w = {a, a} >> sh; return w[31:0]; end
        endcase
    endfunction

    // Carry is the last bit shifted out; shamt 0 passes the carry-in through
    function automatic logic ref_carry(logic [31:0] a, logic [4:0] sh, logic [1:0] t, logic cin);
        logic [63:0] w;
        logic [31:0] y;
        if (sh == 5'd0) return cin;
        case (t)
            2'b00:   begin w = {32'b0, a} << sh; return w[32]; end
            2'b01,
            2'b10:   begin w = {a, 32'b0} >> sh; return w[31]; end
            default: begin y = ref_shift(a, sh, t); return y[31]; end
        endcase
    endfunction

    assign shy[0] = ref_shift(sha[0], shs[0], sht[0]);
    assign shy[1] = ref_shift(sha[1], shs[1], sht[1]);

    shift_arbiter #(.PRIO_REQ0(0)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(v0), .req0_ready(rdy0[0]), .req0_a(a0), .req0_shamt(s0), .req0_shtype(t0),
        .req1_valid(v1), .req1_ready(rdy1[0]), .req1_a(a1), .req1_shamt(s1), .req1_shtype(t1),
`ifdef SHIFT_ARB_CARRY_EN
        .req0_cin(cin0), .req1_cin(cin1), .rsp_c(rc[0]),
`endif
        .sh_a(sha[0]), .sh_shamt(shs[0]), .sh_shtype(sht[0]), .sh_y(shy[0]),
        .rsp_valid(rv[0]), .rsp_ready(rr), .rsp_y(ry[0]), .rsp_id(rid[0])
    );

    shift_arbiter #(.PRIO_REQ0(1)) u_fp (
        .clk(clk), .reset_n(reset_n),
        .req0_valid(v0), .req0_ready(rdy0[1]), .req0_a(a0), .req0_shamt(s0), .req0_shtype(t0),
        .req1_valid(v1), .req1_ready(rdy1[1]), .req1_a(a1), .req1_shamt(s1), .req1_shtype(t1),
`ifdef SHIFT_ARB_CARRY_EN
        .req0_cin(cin0), .req1_cin(cin1), .rsp_c(rc[1]),
`endif
        .sh_a(sha[1]), .sh_shamt(shs[1]), .sh_shtype(sht[1]), .sh_y(shy[1]),
        .rsp_valid(rv[1]), .rsp_ready(rr), .rsp_y(ry[1]), .rsp_id(rid[1])
    );

`ifndef SHIFT_ARB_CARRY_EN
    assign rc[0] = 1'b0;
    assign rc[1] = 1'b0;
`endif

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s dut%0d actual=%h expected=%h at cycle %0d", name, d, act, exp, cyc);
        end
    endtask

    function automatic int qsize(int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qfront(int d);
        if (d == 0) return q0[0];
        return q1[0];
    endfunction

    task automatic qpush(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    // Called one step after inputs are applied: predict grants, check readies, push expectations
    task automatic step();
        #1;
        for (int d = 0; d < 2; d++) begin
            logic acc, win;
            exp_t e;
            acc = 1'b0;
            win = 1'b0;
            if (reset_n && !busy[d] && (v0 || v1)) begin
                acc = 1'b1;
                if (v0 && v1) win = (d == 1) ? 1'b0 : ptr[d];
                else          win = v1;
                e.id  = win;
                e.y   = win ? ref_shift(a1, s1, t1) : ref_shift(a0, s0, t0);
                e.c   = win ? ref_carry(a1, s1, t1, cin1) : ref_carry(a0, s0, t0, cin0);
                e.due = cyc + 2;
                qpush(d, e);
                busy[d] = 1'b1;
                ptr[d]  = ~win;
            end
            check("req0_ready", d, {31'b0, rdy0[d]}, {31'b0, acc && !win});
            check("req1_ready", d, {31'b0, rdy1[d]}, {31'b0, acc && win});
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset now, check cleared outputs, drop all in-flight expectations
    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check("rst_rsp_valid", d, {31'b0, rv[d]}, 32'd0);
            check("rst_rsp_y", d, ry[d], 32'd0);
            check("rst_rsp_id", d, {31'b0, rid[d]}, 32'd0);
            check("rst_sh_a", d, sha[d], 32'd0);
`ifdef SHIFT_ARB_CARRY_EN
            check("rst_rsp_c", d, {31'b0, rc[d]}, 32'd0);
`endif
            busy[d] = 1'b0;
            ptr[d]  = 1'b0;
        end
        q0.delete();
        q1.delete();
        step();
        reset_n = 1'b1;
    endtask

    // Monitor: compare the response channel against the head of each scoreboard
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic want;
            exp_t e;
            want = 1'b0;
            e    = '0;
            if (reset_n && qsize(d) != 0) begin
                e    = qfront(d);
                want = (cyc >= e.due);
            end
            check("rsp_valid", d, {31'b0, rv[d]}, {31'b0, want});
            if (want && rv[d]) begin
                check("rsp_y", d, ry[d], e.y);
                check("rsp_id", d, {31'b0, rid[d]}, {31'b0, e.id});
`ifdef SHIFT_ARB_CARRY_EN
                check("rsp_c", d, {31'b0, rc[d]}, {31'b0, e.c});
`endif
                if (rr) begin
                    qpop(d);
                    busy[d] = 1'b0;
                end
            end
        end
    end

    task automatic set_req(input logic nv0, input logic [31:0] na0, input logic [4:0] ns0, input logic [1:0] nt0,
                           input logic nv1, input logic [31:0] na1, input logic [4:0] ns1, input logic [1:0] nt1);
        v0 = nv0; a0 = na0; s0 = ns0; t0 = nt0;
        v1 = nv1; a1 = na1; s1 = ns1; t1 = nt1;
    endtask

    initial begin
        reset_n = 1'b0;
        rr      = 1'b0;
        cin0    = 1'b0;
        cin1    = 1'b0;
        set_req(1'b1, 32'h1234_5678, 5'd3, 2'b00, 1'b1, 32'h8765_4321, 5'd2, 2'b01);
        busy[0] = 1'b0; busy[1] = 1'b0;
        ptr[0]  = 1'b0; ptr[1]  = 1'b0;
        @(posedge clk);
        #1;
        step();
        do_reset();

        // Single requester LSL
        rr = 1'b1;
        set_req(1'b1, 32'h8000_0001, 5'd4, 2'b00, 1'b0, '0, '0, '0);
        step();
        v0 = 1'b0;
        repeat (3) step();

        // Both requesters valid continuously
        do_reset();
        set_req(1'b1, 32'h8000_0000, 5'd31, 2'b10, 1'b1, 32'h0000_000F, 5'd4, 2'b11);
        repeat (13) step();

        // Response back-pressure held in RESP
        set_req(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        repeat (3) step();
        rr = 1'b0;
        set_req(1'b1, 32'hDEAD_BEEF, 5'd7, 2'b11, 1'b1, 32'h0F0F_0F0F, 5'd0, 2'b10);
        repeat (8) step();
        rr = 1'b1;
        repeat (6) step();

        // Reset during EXEC discards the operation
        set_req(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        repeat (3) step();
        set_req(1'b1, 32'hFFFF_0000, 5'd5, 2'b01, 1'b0, '0, '0, '0);
        step();
        do_reset();
        set_req(1'b0, '0, '0, '0, 1'b1, 32'h0000_0100, 5'd8, 2'b01);
        step();
        v1 = 1'b0;
        repeat (3) step();

`ifdef SHIFT_ARB_CARRY_EN
        // Carry-out: shifted-out bit, then shamt 0 passthrough of cin
        cin0 = 1'b0;
        set_req(1'b1, 32'h0000_0003, 5'd1, 2'b01, 1'b0, '0, '0, '0);
        step();
        v0 = 1'b0;
        repeat (3) step();
        cin0 = 1'b1;
        set_req(1'b1, 32'h0000_0003, 5'd0, 2'b01, 1'b0, '0, '0, '0);
        step();
        v0 = 1'b0;
        repeat (3) step();
`endif

        // Randomized traffic
        for (int i = 0; i < 500; i++) begin
            set_req(($urandom % 3) != 0, $urandom, 5'($urandom), 2'($urandom),
                    ($urandom % 3) != 0, $urandom, 5'($urandom), 2'($urandom));
            if (($urandom % 8) == 0) s0 = 5'd0;
            cin0 = 1'($urandom);
            cin1 = 1'($urandom);
            rr   = ($urandom % 4) != 0;
            step();
        end

        // Drain with a bounded wait
        set_req(1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
        rr = 1'b1;
        for (int i = 0; i < 20 && (q0.size() != 0 || q1.size() != 0); i++) step();
        check("drain_q0", 0, q0.size(), 32'd0);
        check("drain_q1", 1, q1.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
